// File: rtl/instr_sequencer.sv
// Program RAM and run/step/halt sequencer that feeds the 20-bit instruction input of simple_cpu.
// Define BREAKPOINT_EN to add an address breakpoint (bp_en, bp_addr, bp_hit).
module instr_sequencer #(
    parameter int                     INSTR_WIDTH = 20,
    parameter int                     PC_BITS     = 5,
    parameter int                     HOLD_CYCLES = 4,
    parameter logic [3:0]             HALT_OP     = 4'hF,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [PC_BITS-1:0]     load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic [PC_BITS:0]       prog_len,
    input  logic                   start,
    input  logic                   step,
    input  logic                   halt_req,
`ifdef BREAKPOINT_EN
    input  logic                   bp_en,
    input  logic [PC_BITS-1:0]     bp_addr,
    output logic                   bp_hit,
`endif
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done,
    output logic                   halted_by_op
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        EXEC,
        HALTED
    } state_t;

    state_t                 state_q;
    logic [PC_BITS-1:0]     pc_q;
    logic [PC_BITS:0]       len_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [INSTR_WIDTH-1:0] rdata_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   by_op_q;
    logic                   run_mode_q;
    logic                   halt_seen_q;
`ifdef BREAKPOINT_EN
    logic                   bp_hit_q;
`endif

    logic [INSTR_WIDTH-1:0] mem [2**PC_BITS];

    logic [PC_BITS-1:0] pc_d;
    logic               len_hit;
    logic               idle_like;

    assign pc_d      = pc_q + 1'b1;
    assign len_hit   = (({1'b0, pc_q} + 1'b1) == len_q);
    assign idle_like = (state_q == IDLE) || (state_q == HALTED);

    // Program store: writes only while not sequencing, read issued during FETCH.
    always_ff @(posedge clk) begin
        if (load_en && idle_like) begin
            mem[load_addr] <= load_data;
        end
        if (state_q == FETCH) begin
            rdata_q <= mem[pc_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            instr_q     <= NOP_INSTR;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            by_op_q     <= 1'b0;
            run_mode_q  <= 1'b0;
            halt_seen_q <= 1'b0;
`ifdef BREAKPOINT_EN
            bp_hit_q    <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef BREAKPOINT_EN
            bp_hit_q <= 1'b0;
`endif
            case (state_q)
                IDLE, HALTED: begin
                    if (start) begin
                        len_q   <= prog_len;
                        by_op_q <= 1'b0;
                        if (prog_len != '0) begin
                            pc_q        <= '0;
                            run_mode_q  <= 1'b1;
                            halt_seen_q <= 1'b0;
                            busy_q      <= 1'b1;
                            done_q      <= 1'b0;
                            state_q     <= FETCH;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= HALTED;
                        end
                    end else if (step && (state_q == IDLE)) begin
                        run_mode_q  <= 1'b0;
                        halt_seen_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= FETCH;
                    end
                end
                FETCH: begin
`ifdef BREAKPOINT_EN
                    if (bp_en && (pc_q == bp_addr) && run_mode_q) begin
                        busy_q   <= 1'b0;
                        bp_hit_q <= 1'b1;
                        state_q  <= IDLE;
                    end else
`endif
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    if (halt_req) begin
                        halt_seen_q <= 1'b1;
                    end
                    if (rdata_q[INSTR_WIDTH-1 -: 4] == HALT_OP) begin
                        instr_q <= NOP_INSTR;
                        by_op_q <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= HALTED;
                    end else begin
                        instr_q <= rdata_q;
                        valid_q <= 1'b1;
                        cnt_q   <= CNT_LOAD;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (halt_req) begin
                        halt_seen_q <= 1'b1;
                    end
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        instr_q <= NOP_INSTR;
                        pc_q    <= pc_d;
                        // Program end outranks a pending halt request or single-step return.
                        if (len_hit) begin
                            by_op_q <= 1'b0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= HALTED;
                        end else if (halt_seen_q || halt_req || !run_mode_q) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign instr_out    = instr_q;
    assign instr_valid  = valid_q;
    assign pc           = pc_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign halted_by_op = by_op_q;
`ifdef BREAKPOINT_EN
    assign bp_hit       = bp_hit_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a cycle table for a free run, then directed
// sequences for HALT_OP, stepping, halt_req, async reset and (if BREAKPOINT_EN) breakpoints.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [19:0] load_data;
    logic [5:0]  progLen;
    logic        start;
    logic        step;
    logic        halt_req;
    logic [19:0] instr_out;
    logic        instr_valid;
    logic [4:0]  pc;
    logic        busy;
    logic        done;
    logic        halted_by_op;
`ifdef BREAKPOINT_EN
    logic        bp_en;
    logic [4:0]  bp_addr;
    logic        bp_hit;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        start;
        logic        step;
        logic        haltReq;
        logic        expValid;
        logic [19:0] expInstr;
        logic [4:0]  expPc;
        logic        expBusy;
        logic        expDone;
        logic        expByOp;
    } vec_t;

    vec_t vecs[$];

    instr_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .prog_len     (progLen),
        .start        (start),
        .step         (step),
        .halt_req     (halt_req),
`ifdef BREAKPOINT_EN
        .bp_en        (bp_en),
        .bp_addr      (bp_addr),
        .bp_hit       (bp_hit),
`endif
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .busy         (busy),
        .done         (done),
        .halted_by_op (halted_by_op)
    );

    always #5 clk = ~clk;

    // Hard stop so a stuck run still reports.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input vec_t v);
        checkOutput({tag, " valid"}, 32'(instr_valid), 32'(v.expValid));
        checkOutput({tag, " instr"}, 32'(instr_out), 32'(v.expInstr));
        checkOutput({tag, " pc"}, 32'(pc), 32'(v.expPc));
        checkOutput({tag, " busy"}, 32'(busy), 32'(v.expBusy));
        checkOutput({tag, " done"}, 32'(done), 32'(v.expDone));
        checkOutput({tag, " byop"}, 32'(halted_by_op), 32'(v.expByOp));
    endtask

    task automatic applyStimulus(input vec_t v);
        start    = v.start;
        step     = v.step;
        halt_req = v.haltReq;
        tick();
    endtask

    task automatic loadWord(input logic [4:0] a, input logic [19:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int validCount;
        logic [19:0] lastValidInstr;
        vec_t rv;

        rst       = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        progLen   = '0;
        start     = 1'b0;
        step      = 1'b0;
        halt_req  = 1'b0;
`ifdef BREAKPOINT_EN
        bp_en     = 1'b0;
        bp_addr   = '0;
`endif
        #12;
        rv = '{1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 5'd0, 1'b0, 1'b0, 1'b0};
        checkAll("reset", rv);
        tick();
        rst = 1'b0;
        tick();

        // Three-instruction free run; row k is the state after the k-th edge from start.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 20'h00000, 5'd0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 5'd0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 20'h10203, 5'd0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h10203, 5'd0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h10203, 5'd0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h10203, 5'd0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 5'd1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 5'd1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 20'h20405, 5'd1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h20405, 5'd1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h20405, 5'd1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h20405, 5'd1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 5'd2, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 5'd2, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 20'h30001, 5'd2, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h30001, 5'd2, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h30001, 5'd2, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h30001, 5'd2, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 5'd3, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 20'h00000, 5'd3, 1'b0, 1'b1, 1'b0});

        loadWord(5'd0, 20'h10203);
        loadWord(5'd1, 20'h20405);
        loadWord(5'd2, 20'h30001);
        progLen = 6'd3;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkAll($sformatf("run c%0d", i), vecs[i]);
        end
        step = 1'b0;

        // HALT_OP at address 1 stops the run before it is issued.
        loadWord(5'd0, 20'h41111);
        loadWord(5'd1, 20'hF0000);
        progLen = 6'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("haltop done cleared", 32'(done), 32'd0);
        checkOutput("haltop busy", 32'(busy), 32'd1);
        tick();
        tick();
        checkOutput("haltop a0 valid", 32'(instr_valid), 32'd1);
        checkOutput("haltop a0 instr", 32'(instr_out), 32'h41111);
        validCount = 0;
        repeat (6) begin
            tick();
            validCount += int'(instr_valid);
        end
        checkOutput("haltop extra issues", 32'(validCount), 32'd0);
        checkOutput("haltop done", 32'(done), 32'd1);
        checkOutput("haltop byop", 32'(halted_by_op), 32'd1);
        checkOutput("haltop pc", 32'(pc), 32'd1);
        checkOutput("haltop instr", 32'(instr_out), 32'h00000);
        checkOutput("haltop busy low", 32'(busy), 32'd0);

        // Two single steps from IDLE.
        pulseReset();
        loadWord(5'd0, 20'h50A0A);
        loadWord(5'd1, 20'h60B0B);
        for (int s = 0; s < 2; s++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            tick();
            tick();
            checkOutput($sformatf("step%0d valid", s), 32'(instr_valid), 32'd1);
            checkOutput($sformatf("step%0d instr", s), 32'(instr_out), (s == 0) ? 32'h50A0A : 32'h60B0B);
            repeat (4) tick();
            checkOutput($sformatf("step%0d busy", s), 32'(busy), 32'd0);
            checkOutput($sformatf("step%0d pc", s), 32'(pc), 32'(s + 1));
            checkOutput($sformatf("step%0d done", s), 32'(done), 32'd0);
            tick();
            checkOutput($sformatf("step%0d idle busy", s), 32'(busy), 32'd0);
        end

        // halt_req during EXEC of address 0 lets the instruction finish, then IDLE.
        loadWord(5'd0, 20'h70001);
        loadWord(5'd1, 20'h70002);
        loadWord(5'd2, 20'h70003);
        loadWord(5'd3, 20'h70004);
        progLen = 6'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("halt valid", 32'(instr_valid), 32'd1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        tick();
        checkOutput("halt still held", 32'(instr_out), 32'h70001);
        tick();
        checkOutput("halt busy", 32'(busy), 32'd0);
        checkOutput("halt pc", 32'(pc), 32'd1);
        checkOutput("halt done", 32'(done), 32'd0);
        checkOutput("halt instr nop", 32'(instr_out), 32'h00000);
        tick();
        checkOutput("halt stays idle", 32'(busy), 32'd0);

        // Reset during the second EXEC cycle; writes attempted while busy must be dropped.
        step = 1'b1;
        tick();
        step = 1'b0;
        load_en   = 1'b1;
        load_addr = 5'd0;
        load_data = 20'h99999;
        tick();
        tick();
        load_en = 1'b0;
        checkOutput("rst a1 valid", 32'(instr_valid), 32'd1);
        tick();
        checkOutput("rst pre instr", 32'(instr_out), 32'h70002);
        checkOutput("rst pre pc", 32'(pc), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst async instr", 32'(instr_out), 32'h00000);
        checkOutput("rst async pc", 32'(pc), 32'd0);
        checkOutput("rst async busy", 32'(busy), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        progLen = 6'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("readback valid", 32'(instr_valid), 32'd1);
        checkOutput("readback instr", 32'(instr_out), 32'h70001);
        repeat (4) tick();
        checkOutput("readback done", 32'(done), 32'd1);
        checkOutput("readback pc", 32'(pc), 32'd1);
        checkOutput("readback byop", 32'(halted_by_op), 32'd0);

`ifdef BREAKPOINT_EN
        // Breakpoint at address 2 stops a free run before that instruction issues.
        pulseReset();
        bp_en   = 1'b1;
        bp_addr = 5'd2;
        progLen = 6'd4;
        validCount = 0;
        lastValidInstr = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (instr_valid) begin
                validCount++;
                lastValidInstr = instr_out;
            end
        end
        checkOutput("bp hit", 32'(bp_hit), 32'd1);
        checkOutput("bp busy", 32'(busy), 32'd0);
        checkOutput("bp pc", 32'(pc), 32'd2);
        checkOutput("bp issues", 32'(validCount), 32'd2);
        checkOutput("bp last issued", 32'(lastValidInstr), 32'h70002);
        tick();
        checkOutput("bp hit pulse", 32'(bp_hit), 32'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        checkOutput("bp step valid", 32'(instr_valid), 32'd1);
        checkOutput("bp step instr", 32'(instr_out), 32'h70003);
        repeat (4) tick();
        checkOutput("bp step pc", 32'(pc), 32'd3);
        checkOutput("bp step busy", 32'(busy), 32'd0);
        bp_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Program store and instruction sequencer that drives the 20-bit instruction input of simple_cpu. It holds a small instruction RAM, loaded over a write port while idle, and a program counter. A run/step/halt FSM presents each instruction for a fixed number of cycles so the CU can complete it. It is the block that steps the CPU datapath through a program.

Parameters:
INSTR_WIDTH, 20, instruction width; opcode is instruction[INSTR_WIDTH-1:INSTR_WIDTH-4]
PC_BITS, 5, program address width (32 entries)
HOLD_CYCLES, 4, cycles each instruction is held on instr_out (>=1)
HALT_OP, 4'hF, opcode that stops sequencing
NOP_INSTR, 20'h00000, value driven on instr_out when no instruction is being held

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
load_en  input  1  program RAM write strobe; honoured only in IDLE or HALTED
load_addr  input  PC_BITS  write address
load_data  input  INSTR_WIDTH  write data
prog_len  input  PC_BITS+1  number of valid instructions, sampled at start
start  input  1  begin a free-running execution from pc=0
step  input  1  execute exactly one instruction from current pc
halt_req  input  1  stop after the current instruction completes
instr_out  output  INSTR_WIDTH  instruction to simple_cpu
instr_valid  output  1  one-cycle pulse on the first hold cycle of each instruction
pc  output  PC_BITS  address of the current/next instruction
busy  output  1  high in FETCH, ISSUE and EXEC
done  output  1  high in HALTED
halted_by_op  output  1  last stop was caused by HALT_OP

Behaviour:
- Reset (async): state=IDLE, pc=0, instr_out=NOP_INSTR, instr_valid=0, busy=0, done=0, halted_by_op=0, run_mode=0, hold counter=0. RAM contents are not reset.
- Program RAM: 2^PC_BITS x INSTR_WIDTH, synchronous write, synchronous read (1-cycle latency). Writes while busy=1 are ignored.
- IDLE: start with prog_len!=0 -> pc=0, run_mode=1, go to FETCH. step -> run_mode=0, go to FETCH at the current pc. start has priority over step. start with prog_len==0 -> HALTED, halted_by_op=0.
- FETCH (1 cycle): RAM read address=pc.
- ISSUE (1 cycle): capture RAM data.
  - Opcode==HALT_OP: instr_out=NOP_INSTR, go to HALTED, halted_by_op=1, pc unchanged.
  - Otherwise: instr_out=data, instr_valid=1 for this cycle, counter=HOLD_CYCLES-1, go to EXEC.
- EXEC: instr_out held. The counter decrements each cycle. At 0, instr_out returns to NOP_INSTR and pc increments.
  - If pc+1==prog_len (latched), the next state is HALTED with halted_by_op=0. pc wraps to 0 when incrementing past 2^PC_BITS-1.
  - If halt_req was seen at any time during ISSUE or EXEC, or run_mode=0, go to IDLE.
  - Otherwise go to FETCH.
  - Latency from start to first instr_valid is 2 cycles. Instruction period is HOLD_CYCLES+2 cycles.
- HALTED: done=1. start restarts from pc=0 and clears done and halted_by_op. step is ignored. load_en is allowed.
- halt_req in IDLE or HALTED has no effect. halt_req and start in the same IDLE cycle: start wins, and halt_req is not latched.
- Reset mid-EXEC: instr_out goes to NOP_INSTR immediately (asynchronous) and the instruction is abandoned.

Optional Feature:
BREAKPOINT_EN
- Defined: the block adds ports bp_en (input 1), bp_addr (input PC_BITS) and bp_hit (output 1).
  - In FETCH, if bp_en=1 and pc==bp_addr and run_mode=1, the block goes to IDLE without issuing and pulses bp_hit for 1 cycle. pc stays at bp_addr.
  - A following step executes that instruction normally. A following start restarts from 0.
- Undefined: the ports are absent and the sequencer never stops on address.

Test Plan:
- Load 3 instructions 20'h1_0203, 20'h2_0405, 20'h3_0001. Set prog_len=3 and pulse start. Required: instr_valid at cycles 2, 8 and 14 with those values; each held 4 cycles; then done=1, halted_by_op=0, pc=3.
- Program with 20'hF_0000 at address 1 and prog_len=5. Required: only address 0 is issued; HALTED with halted_by_op=1 and pc=1; instr_out=NOP_INSTR.
- Pulse step twice from IDLE. Required: one instruction per pulse, returning to IDLE each time; pc goes 0→1→2; busy low between the two.
- Pulse halt_req during the EXEC of address 0 on a 4-instruction program. Required: the instruction completes its full hold, then IDLE with pc=1 and done=0.
- Assert rst during the 2nd EXEC cycle. Required: instr_out=0 and pc=0 in the same cycle. A load_en attempt while busy leaves RAM unchanged, checked by a readback run.
- With BREAKPOINT_EN defined, set bp_addr=2 and run a 4-instruction program. Required: bp_hit pulses, the FSM returns to IDLE with pc=2, and the instruction at address 2 has not been issued. A following step issues address 2.
